datapath: RTL and testbench

Multicycle ARM datapath that consumes the control signals issued by `controller` and returns `Instr[31:12]` and `ALUFlags` to it. It holds all architectural and non-architectural state: PC, register file R0–R14, instruction register, data register, A/B operand registers and ALUOut. It drives a unified external memory through `Adr`/`WriteData` and samples `ReadData`.

---
 rtl/arm_pkg.sv | 47 ++++
 rtl/datapath_alu.sv | 42 ++++
 rtl/datapath.sv | 112 +++++++++++
 tb/tb_datapath.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the multicycle ARM datapath and controller.
// Mux selects, ALU ops and flag bit positions.
package arm_pkg;

  typedef enum logic [1:0] {
    SRCA_REG   = 2'b00,
    SRCA_PC    = 2'b01,
    SRCA_ZERO  = 2'b10,
    SRCA_ZERO2 = 2'b11
  } aluSrcA_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10,
    SRCB_ZERO = 2'b11
  } aluSrcB_e;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_DATA    = 2'b01,
    RES_ALU     = 2'b10,
    RES_ALUOUT2 = 2'b11
  } resultSrc_e;

  typedef enum logic [1:0] {
    IMM_8   = 2'b00,
    IMM_12  = 2'b01,
    IMM_BR  = 2'b10,
    IMM_NONE = 2'b11
  } immSrc_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } aluCtl_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/datapath_alu.sv
// 32-bit ALU: ADD, SUB, AND, ORR with {N,Z,C,V} flags.
// SUB is A + ~B + 1 so C reads as "no borrow".
module alu
  import arm_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  ctl,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic        isSub;
  logic        carry;
  logic        ovf;
  logic [31:0] bIn;
  logic [32:0] sum;

  always_comb begin
    isSub  = (aluCtl_e'(ctl) == ALU_SUB);
    bIn    = isSub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bIn} + {32'd0, isSub};
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (aluCtl_e'(ctl))
      ALU_ADD, ALU_SUB: begin
        result = sum[31:0];
        carry  = sum[32];
        ovf    = (a[31] == bIn[31]) && (sum[31] != a[31]);
      end
      ALU_AND: result = a & b;
      default: result = a | b;
    endcase
    flags         = '0;
    flags[FLAG_N] = result[31];
    flags[FLAG_Z] = (result == 32'd0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/datapath.sv
// Multicycle ARM datapath: PC, R0-R14, IR, Data, A, B, ALUOut.
// R15 reads return the live Result bus, which is PC+8 in decode.
module datapath
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ReadData,
  input  logic        PCWrite,
  input  logic        RegWrite,
  input  logic        IRWrite,
  input  logic        AdrSrc,
  input  logic [1:0]  RegSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ResultSrc,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUControl,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic [19:0] Instr,
  output logic [3:0]  ALUFlags
);

  logic [31:0] pc, ir, dataReg;
  logic [31:0] aReg, bReg, aluOut;
  logic [31:0] rf [15];

  logic [3:0]  ra1, ra2, rd;
  logic [31:0] rd1, rd2, extImm;
  logic [31:0] srcA, srcB;
  logic [31:0] aluResult, result;

  assign ra1 = RegSrc[0] ? PC_REG : ir[19:16];
  assign ra2 = RegSrc[1] ? ir[15:12] : ir[3:0];
  assign rd  = ir[15:12];

  assign rd1 = (ra1 == PC_REG) ? result : rf[ra1];
  assign rd2 = (ra2 == PC_REG) ? result : rf[ra2];

  always_comb begin
    extImm = '0;
    unique case (immSrc_e'(ImmSrc))
      IMM_8:   extImm = {24'd0, ir[7:0]};
      IMM_12:  extImm = {20'd0, ir[11:0]};
      IMM_BR:  extImm = {{6{ir[23]}}, ir[23:0], 2'b00};
      default: extImm = '0;
    endcase
  end

  always_comb begin
    srcA = '0;
    unique case (aluSrcA_e'(ALUSrcA))
      SRCA_REG: srcA = aReg;
      SRCA_PC:  srcA = pc;
      default:  srcA = '0;
    endcase
  end

  always_comb begin
    srcB = '0;
    unique case (aluSrcB_e'(ALUSrcB))
      SRCB_REG:  srcB = bReg;
      SRCB_IMM:  srcB = extImm;
      SRCB_FOUR: srcB = 32'd4;
      default:   srcB = '0;
    endcase
  end

  alu uAlu (
    .a      (srcA),
    .b      (srcB),
    .ctl    (ALUControl),
    .result (aluResult),
    .flags  (ALUFlags)
  );

  always_comb begin
    result = aluOut;
    unique case (resultSrc_e'(ResultSrc))
      RES_DATA: result = dataReg;
      RES_ALU:  result = aluResult;
      default:  result = aluOut;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc;
  assign WriteData = bReg;
  assign Instr     = ir[31:12];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      dataReg <= '0;
      aReg    <= '0;
      bReg    <= '0;
      aluOut  <= '0;
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite) ir <= ReadData;
      dataReg <= ReadData;
      aReg    <= rd1;
      bReg    <= rd2;
      aluOut  <= aluResult;
      // PC is only ever changed through PCWrite
      if (RegWrite && rd != PC_REG) rf[rd] <= result;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Scenario bench for datapath: expected values queued at stimulus,
// popped and compared when the DUT output is sampled.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ReadData;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB;
  logic [1:0]  ResultSrc, ImmSrc, ALUControl;
  logic [31:0] Adr, WriteData;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb [$];
  logic [31:0] e;

  datapath dut (
    .clk        (clk),
    .reset      (reset),
    .ReadData   (ReadData),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0;
    RegSrc = 0; ALUSrcA = 0; ALUSrcB = 0;
    ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic loadIr(input logic [31:0] w);
    idle();
    ReadData = w;
    IRWrite = 1;
    tick();
    IRWrite = 0;
  endtask

  task automatic fetch(input logic [31:0] w);
    idle();
    ReadData = w;
    IRWrite = 1; PCWrite = 1;
    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    tick();
    idle();
  endtask

  // route register r through A and the ALU (+0) onto Adr
  task automatic showReg(input logic [3:0] r);
    loadIr({12'h0, r, 16'h0});
    tick();
    ALUSrcA = 2'b00; ALUSrcB = 2'b11; ALUControl = 2'b00;
    ResultSrc = 2'b10; AdrSrc = 1;
    #1;
  endtask

  task automatic setImm(input logic [3:0] rd, input logic [7:0] imm);
    loadIr({16'h0, rd, 4'h0, imm});
    ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 2'b00;
    ResultSrc = 2'b10; RegWrite = 1;
    tick();
    idle();
  endtask

  task automatic ldReg(input logic [3:0] rd, input logic [31:0] v);
    loadIr({16'h0, rd, 12'h0});
    ReadData = v;
    tick();
    ResultSrc = 2'b01; RegWrite = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    ReadData = 32'hA5A5_5A5A;
    PCWrite = 1; IRWrite = 1; RegWrite = 1;
    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    reset = 1;
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    tick();
    tick();
    reset = 0;
    idle();
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL reset_adr: got %h want %h", Adr, e); end
    e = sb.pop_front(); vectors++;
    if ({12'h0, Instr} !== e) begin miscompares++; $display("FAIL reset_instr: got %h want %h", Instr, e); end
    e = sb.pop_front(); vectors++;
    if (WriteData !== e) begin miscompares++; $display("FAIL reset_wdata: got %h want %h", WriteData, e); end
    for (int i = 0; i < 15; i++) begin
      sb.push_back(32'h0);
      showReg(4'(i));
      e = sb.pop_front(); vectors++;
      if (Adr !== e) begin miscompares++; $display("FAIL reset_r%0d: got %h want %h", i, Adr, e); end
    end
  endtask

  task automatic test_fetch();
    doReset();
    ReadData = 32'hE282_1002;
    IRWrite = 1; PCWrite = 1;
    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    sb.push_back(32'h0);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL fetch_adr_pre: got %h want %h", Adr, e); end
    sb.push_back(32'h000E_2821); sb.push_back(32'h4);
    tick();
    idle();
    #1;
    e = sb.pop_front(); vectors++;
    if ({12'h0, Instr} !== e) begin miscompares++; $display("FAIL fetch_instr: got %h want %h", Instr, e); end
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL fetch_pc: got %h want %h", Adr, e); end
  endtask

  task automatic test_add_imm();
    setImm(4'd2, 8'd7);
    loadIr(32'hE282_1002);
    tick();
    ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 2'b00;
    sb.push_back(32'h0);
    #1;
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL add_flags: got %b want %b", ALUFlags, e[3:0]); end
    tick();
    idle();
    ResultSrc = 2'b00; RegWrite = 1;
    tick();
    idle();
    sb.push_back(32'd9);
    showReg(4'd1);
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL add_r1: got %h want %h", Adr, e); end
  endtask

  task automatic test_sub_flags();
    setImm(4'd3, 8'd5);
    loadIr(32'h0003_0003);
    tick();
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = 2'b01;
    sb.push_back(32'b0110); sb.push_back(32'd5);
    #1;
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL sub_flags: got %b want %b", ALUFlags, e[3:0]); end
    e = sb.pop_front(); vectors++;
    if (WriteData !== e) begin miscompares++; $display("FAIL sub_breg: got %h want %h", WriteData, e); end
    ALUSrcB = 2'b11; ALUControl = 2'b10;
    sb.push_back(32'b0100);
    #1;
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL and_flags: got %b want %b", ALUFlags, e[3:0]); end
    ALUSrcB = 2'b00; ALUControl = 2'b11; ResultSrc = 2'b10; AdrSrc = 1;
    sb.push_back(32'b0000); sb.push_back(32'd5);
    #1;
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL orr_flags: got %b want %b", ALUFlags, e[3:0]); end
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL orr_result: got %h want %h", Adr, e); end
    ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = 2'b11; ALUControl = 2'b00;
    sb.push_back(32'h0); sb.push_back(32'b0100);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL zero_srcs: got %h want %h", Adr, e); end
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL zero_flags: got %b want %b", ALUFlags, e[3:0]); end
    idle();
  endtask

  task automatic test_overflow();
    ldReg(4'd4, 32'h7FFF_FFFF);
    loadIr(32'h0004_0001);
    tick();
    ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 2'b00;
    ResultSrc = 2'b10; AdrSrc = 1;
    sb.push_back(32'b1001); sb.push_back(32'h8000_0000);
    #1;
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL ovf_flags: got %b want %b", ALUFlags, e[3:0]); end
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL ovf_result: got %h want %h", Adr, e); end
    ALUControl = 2'b01;
    sb.push_back(32'b0010); sb.push_back(32'h7FFF_FFFE);
    #1;
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL subc_flags: got %b want %b", ALUFlags, e[3:0]); end
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL subc_result: got %h want %h", Adr, e); end
    idle();
  endtask

  task automatic test_branch();
    doReset();
    fetch(32'hE1A0_0000);
    fetch(32'hE1A0_0000);
    fetch(32'hEAFF_FFFE);
    RegSrc = 2'b01; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    sb.push_back(32'd12);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL br_pc: got %h want %h", Adr, e); end
    tick();
    idle();
    ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b10; ALUControl = 2'b00;
    ResultSrc = 2'b10; PCWrite = 1; AdrSrc = 1;
    sb.push_back(32'd8); sb.push_back(32'b0010);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL br_target: got %h want %h", Adr, e); end
    e = sb.pop_front(); vectors++;
    if ({28'h0, ALUFlags} !== e) begin miscompares++; $display("FAIL br_flags: got %b want %b", ALUFlags, e[3:0]); end
    sb.push_back(32'd8);
    tick();
    idle();
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL br_newpc: got %h want %h", Adr, e); end
  endtask

  task automatic test_mem();
    ldReg(4'd5, 32'hCAFE_F00D);
    ldReg(4'd6, 32'h0000_0100);
    loadIr(32'hE586_5004);
    RegSrc = 2'b10;
    tick();
    sb.push_back(32'hCAFE_F00D);
    e = sb.pop_front(); vectors++;
    if (WriteData !== e) begin miscompares++; $display("FAIL str_wdata: got %h want %h", WriteData, e); end
    ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b01; ALUControl = 2'b00;
    tick();
    AdrSrc = 1; ResultSrc = 2'b00;
    sb.push_back(32'h104); sb.push_back(32'hCAFE_F00D);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL str_adr: got %h want %h", Adr, e); end
    e = sb.pop_front(); vectors++;
    if (WriteData !== e) begin miscompares++; $display("FAIL str_wdata_mem: got %h want %h", WriteData, e); end
    idle();
    loadIr(32'hE596_7004);
    tick();
    ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b01; ALUControl = 2'b00;
    tick();
    idle();
    AdrSrc = 1; ResultSrc = 2'b00; ReadData = 32'h1234_5678;
    sb.push_back(32'h104);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL ldr_adr: got %h want %h", Adr, e); end
    tick();
    idle();
    ResultSrc = 2'b01; RegWrite = 1;
    tick();
    idle();
    sb.push_back(32'h1234_5678);
    showReg(4'd7);
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL ldr_r7: got %h want %h", Adr, e); end
    loadIr(32'hE596_F004);
    ReadData = 32'hDEAD_BEEC;
    tick();
    ResultSrc = 2'b01; RegWrite = 1;
    tick();
    idle();
    sb.push_back(32'd8);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL ldr_r15_pc: got %h want %h", Adr, e); end
  endtask

  task automatic test_reset_mid();
    idle();
    ReadData = 32'hFFFF_FFFF;
    PCWrite = 1; IRWrite = 1; RegWrite = 1;
    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    reset = 1;
    tick();
    reset = 0;
    idle();
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL mid_adr: got %h want %h", Adr, e); end
    e = sb.pop_front(); vectors++;
    if ({12'h0, Instr} !== e) begin miscompares++; $display("FAIL mid_instr: got %h want %h", Instr, e); end
    e = sb.pop_front(); vectors++;
    if (WriteData !== e) begin miscompares++; $display("FAIL mid_wdata: got %h want %h", WriteData, e); end
    sb.push_back(32'h0);
    showReg(4'd7);
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL mid_r7: got %h want %h", Adr, e); end
  endtask

  task automatic test_read_during_write();
    loadIr(32'h0008_8055);
    ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 2'b00;
    ResultSrc = 2'b10; RegWrite = 1;
    tick();
    idle();
    ALUSrcA = 2'b00; ALUSrcB = 2'b11; ALUControl = 2'b00;
    ResultSrc = 2'b10; AdrSrc = 1;
    sb.push_back(32'h0); sb.push_back(32'h55);
    #1;
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL rdw_old: got %h want %h", Adr, e); end
    tick();
    e = sb.pop_front(); vectors++;
    if (Adr !== e) begin miscompares++; $display("FAIL rdw_new: got %h want %h", Adr, e); end
    idle();
  endtask

  initial begin
    reset = 1;
    ReadData = '0;
    idle();
    test_reset();
    test_fetch();
    test_add_imm();
    test_sub_flags();
    test_overflow();
    test_branch();
    test_mem();
    test_reset_mid();
    test_read_during_write();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
